// File: rtl/exception_unit_if.sv
// Signal bundle between the exception sequencer and the control unit,
// PC/EPC registers and memory mux. The sequencer side uses the slave modport.
interface exception_unit_if #(
    parameter int N_SRC = 3
);
    logic [N_SRC-1:0] excpt_req;
    logic [N_SRC-1:0] excpt_mask;
    logic [31:0]      pc_in;
    logic [7:0]       mem_rdata;
    logic             busy;
    logic             mem_rd;
    logic [31:0]      vec_addr;
    logic [31:0]      new_pc;
    logic             pc_load;
    logic [31:0]      epc_out;
    logic [N_SRC-1:0] cause_out;

    modport master (
        output excpt_req, excpt_mask, pc_in, mem_rdata,
        input  busy, mem_rd, vec_addr, new_pc, pc_load, epc_out, cause_out
    );

    modport slave (
        input  excpt_req, excpt_mask, pc_in, mem_rdata,
        output busy, mem_rd, vec_addr, new_pc, pc_load, epc_out, cause_out
    );
endinterface

// File: rtl/exception_unit.sv
// Exception sequencer: latches requests, picks the highest enabled index,
// saves EPC, fetches the handler byte from the vector table and loads the PC.
module exception_unit #(
    parameter int N_SRC    = 3,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    exception_unit_if.slave  bus
);
    localparam int         SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [2:0] LAT   = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [N_SRC-1:0] pending_reg, pending_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [2:0]       cnt_reg, cnt_next;
    logic [31:0]      epc_reg, epc_next;
    logic [N_SRC-1:0] cause_reg, cause_next;
    logic [31:0]      new_pc_reg, new_pc_next;

    logic [N_SRC-1:0] trigger;
    logic [N_SRC-1:0] clr;
    logic [SEL_W-1:0] hi_idx;

    assign trigger = (pending_reg | bus.excpt_req) & bus.excpt_mask;

    // The serviced bit clears only in LOAD; a same-cycle request re-sets it below.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_clr
            assign clr[gi] = (state_reg == LOAD) && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (trigger[i]) hi_idx = SEL_W'(i);
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        cnt_next     = cnt_reg;
        epc_next     = epc_reg;
        cause_next   = cause_reg;
        new_pc_next  = new_pc_reg;
        pending_next = (pending_reg & ~clr) | bus.excpt_req;
        case (state_reg)
            IDLE: begin
                if (|trigger) begin
                    state_next = FETCH;
                    sel_next   = hi_idx;
                    epc_next   = bus.pc_in - 32'd4;
                    cause_next = N_SRC'(1) << hi_idx;
                    cnt_next   = '0;
                end
            end
            FETCH: begin
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == LAT) begin
                    new_pc_next = {24'b0, bus.mem_rdata};
                    state_next  = LOAD;
                end
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            sel_reg     <= '0;
            cnt_reg     <= '0;
            epc_reg     <= '0;
            cause_reg   <= '0;
            new_pc_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            sel_reg     <= sel_next;
            cnt_reg     <= cnt_next;
            epc_reg     <= epc_next;
            cause_reg   <= cause_next;
            new_pc_reg  <= new_pc_next;
        end
    end

    // Pure decodes of the state register, so they drop with an asynchronous reset.
    assign bus.busy      = (state_reg != IDLE);
    assign bus.mem_rd    = (state_reg == FETCH);
    assign bus.vec_addr  = (state_reg == FETCH) ? (32'(VEC_BASE) + 32'(sel_reg)) : 32'd0;
    assign bus.pc_load   = (state_reg == LOAD);
    assign bus.new_pc    = new_pc_reg;
    assign bus.epc_out   = epc_reg;
    assign bus.cause_out = cause_reg;
endmodule
